// File: rtl/infer_argmax_ctrl.sv
// infer_argmax_ctrl: sequences one inference on an external engine (clear
// pulse, start pulse, bounded wait for completion), then scans the ten class
// scores one per cycle and presents the signed argmax to the host until it
// acknowledges.
//
// Handshakes: req is seen only in IDLE and is a level sampled on the rising
// edge; res_valid stays high in RESULT with res_* frozen until ack is sampled
// high, and the controller is back in IDLE on the following cycle. ack outside
// RESULT and req outside IDLE have no effect.
module infer_argmax_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  ack,
   output logic                  busy,
   output logic                  eng_reset,
   output logic                  eng_start,
   input  logic                  eng_done,
   output logic [3:0]            out_idx,
   input  logic [DATA_WIDTH-1:0] eng_out,
   output logic                  res_valid,
   output logic [3:0]            res_digit,
   output logic [DATA_WIDTH-1:0] res_score,
   output logic                  res_err,
   output logic [2:0]            dbg_state_o
);

   // One bit of headroom so the counter can never wrap while waiting.
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [3:0]       IDX_LAST = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLR    = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_SCAN   = 3'd4,
      S_RESULT = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [3:0]             idx_q, idx_d;
   logic [3:0]             best_idx_q, best_idx_d;
   logic [DATA_WIDTH-1:0]  best_score_q, best_score_d;
   logic                   err_q, err_d;

   // Next-state and datapath updates; every register holds unless told otherwise.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      best_idx_d   = best_idx_q;
      best_score_d = best_score_q;
      err_d        = err_q;
      case (state_q)
         S_IDLE: begin
            if (req) state_d = S_CLR;
         end
         S_CLR: begin
            state_d = S_START;
         end
         S_START: begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Completion is only trusted here, after the engine was cleared.
            if (eng_done) begin
               idx_d   = 4'd0;
               state_d = S_SCAN;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_RESULT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_SCAN: begin
            // Strict compare keeps the lowest index on ties.
            if ((idx_q == 4'd0) || ($signed(eng_out) > $signed(best_score_q))) begin
               best_score_d = eng_out;
               best_idx_d   = idx_q;
            end
            if (idx_q == IDX_LAST) begin
               idx_d   = 4'd0;
               err_d   = 1'b0;
               state_d = S_RESULT;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         S_RESULT: begin
            if (ack) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= 4'd0;
         best_idx_q   <= 4'd0;
         best_score_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         best_idx_q   <= best_idx_d;
         best_score_q <= best_score_d;
         err_q        <= err_d;
      end
   end

   // Outputs are pure decodes of registered state, so pulses last one cycle.
   assign busy        = (state_q != S_IDLE);
   assign eng_reset   = (state_q == S_CLR);
   assign eng_start   = (state_q == S_START);
   assign out_idx     = (state_q == S_SCAN) ? idx_q : 4'd0;
   assign res_valid   = (state_q == S_RESULT);
   assign res_digit   = best_idx_q;
   assign res_score   = best_score_q;
   assign res_err     = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_infer_argmax_ctrl.sv
// Bench for infer_argmax_ctrl: a behavioural engine model answers the
// clear/start pulses, a table of directed vectors plus randomized score sets
// are run through the controller, and results are compared against an argmax
// reference model and an arithmetic latency model.
module tb_infer_argmax_ctrl;

   localparam int DW = 16;
   localparam int T  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req = 1'b0;
   logic          ack = 1'b0;
   logic          busy, eng_reset, eng_start;
   logic          eng_done = 1'b0;
   logic [3:0]    out_idx;
   logic [DW-1:0] eng_out;
   logic          res_valid;
   logic [3:0]    res_digit;
   logic [DW-1:0] res_score;
   logic          res_err;
   logic [2:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   infer_argmax_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .req(req), .ack(ack), .busy(busy),
      .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
      .out_idx(out_idx), .eng_out(eng_out), .res_valid(res_valid),
      .res_digit(res_digit), .res_score(res_score), .res_err(res_err),
      .dbg_state_o(dbg_state)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Engine model: scores are a combinational lookup; done rises eng_delay
   // cycles after the start pulse (never when negative) and stays high.
   logic [DW-1:0] scores [10];
   int eng_delay = 1;
   int eng_rem   = 0;

   always_comb begin
      eng_out = '0;
      for (int i = 0; i < 10; i++)
         if (int'(out_idx) == i) eng_out = scores[i];
   end

   always @(negedge clk) begin
      if (eng_start) begin
         eng_done = 1'b0;
         eng_rem  = eng_delay;
      end else if (eng_rem > 0) begin
         eng_rem--;
         if (eng_rem == 0) eng_done = 1'b1;
      end
   end

   // Pulse monitor: counts engine pulses and checks out_idx bounds every cycle.
   int n_reset = 0;
   int n_start = 0;
   bit prev_reset = 1'b0;
   bit mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (eng_reset) n_reset++;
         if (eng_start) begin
            n_start++;
            chk("start_follows_reset", prev_reset, 1);
         end
         chk("out_idx_bounds",
             (out_idx <= 4'd9) && (out_idx == 4'd0 || (busy && !res_valid)), 1);
      end
      prev_reset = eng_reset;
   end

   // Reference argmax: first index holding the maximum signed score.
   function automatic void ref_argmax(input logic [9:0][DW-1:0] sc,
                                      output logic [3:0] d, output logic [DW-1:0] s);
      int best;
      int bi;
      best = int'($signed(sc[0]));
      bi   = 0;
      for (int i = 1; i < 10; i++)
         if (int'($signed(sc[i])) > best) begin
            best = int'($signed(sc[i]));
            bi   = i;
         end
      d = 4'(bi);
      s = sc[bi];
   endfunction

   task automatic chk_reset_values(input string tag);
      chk({tag, "_busy"},      busy, 0);
      chk({tag, "_eng_reset"}, eng_reset, 0);
      chk({tag, "_eng_start"}, eng_start, 0);
      chk({tag, "_out_idx"},   out_idx, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_digit"}, res_digit, 0);
      chk({tag, "_res_score"}, res_score, 0);
      chk({tag, "_res_err"},   res_err, 0);
   endtask

   // One full transaction, starting at a negedge with req raised immediately.
   task automatic run_inf(input logic [9:0][DW-1:0] sc, input int delay,
                          input bit exp_err, input logic [3:0] exp_digit,
                          input logic [DW-1:0] exp_score, input int hold,
                          input bit ack_with_req, input string tag);
      int  t0;
      int  exp_cyc;
      bit  got;
      logic [3:0]    d0;
      logic [DW-1:0] s0;
      logic          e0;
      for (int i = 0; i < 10; i++) scores[i] = sc[i];
      eng_delay = delay;
      n_reset = 0;
      n_start = 0;
      t0  = cyc;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      exp_cyc = exp_err ? (t0 + 3 + T) : (t0 + 13 + delay);
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (res_valid) begin
            got = 1'b1;
            break;
         end
         ack = 1'($urandom_range(0, 1));
         req = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      ack = 1'b0;
      req = 1'b0;
      chk({tag, "_res_valid_seen"}, got, 1);
      chk({tag, "_latency"}, cyc, exp_cyc);
      chk({tag, "_res_err"}, res_err, exp_err);
      if (!exp_err) begin
         chk({tag, "_res_digit"}, res_digit, exp_digit);
         chk({tag, "_res_score"}, res_score, exp_score);
      end
      chk({tag, "_eng_reset_pulses"}, n_reset, 1);
      chk({tag, "_eng_start_pulses"}, n_start, 1);
      d0 = res_digit;
      s0 = res_score;
      e0 = res_err;
      for (int h = 0; h < hold; h++) begin
         req = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk({tag, "_hold_valid"}, res_valid, 1);
         chk({tag, "_hold_stable"}, {res_digit, res_score, res_err}, {d0, s0, e0});
      end
      req = ack_with_req;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      req = 1'b0;
      chk({tag, "_ack_drop_valid"}, res_valid, 0);
      chk({tag, "_ack_idle"}, busy, 0);
      @(negedge clk);
      chk({tag, "_idle_after"}, busy, 0);
   endtask

   typedef struct {
      logic [9:0][DW-1:0] sc;
      int                 delay;
      bit                 err;
      logic [3:0]         digit;
      logic [DW-1:0]      score;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int s_mix  [10] = '{5, -3, 100, 7, 0, 100, -50, 2, 1, 99};
      int s_neg  [10] = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
      int s_rise [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 32767};
      logic [9:0][DW-1:0] rs;
      logic [3:0]    rd;
      logic [DW-1:0] rv;
      bit            seen;

      for (int i = 0; i < 10; i++) begin
         tbl[0].sc[i] = 16'(s_mix[i]);
         tbl[1].sc[i] = 16'h8000;
         tbl[2].sc[i] = 16'(s_neg[i]);
         tbl[3].sc[i] = 16'(s_rise[i]);
         tbl[4].sc[i] = 16'(i);
      end
      tbl[0].delay = 3;  tbl[0].err = 0; tbl[0].digit = 4'd2; tbl[0].score = 16'd100;
      tbl[1].delay = 1;  tbl[1].err = 0; tbl[1].digit = 4'd0; tbl[1].score = 16'h8000;
      tbl[2].delay = 2;  tbl[2].err = 0; tbl[2].digit = 4'd0; tbl[2].score = 16'hFFFF;
      tbl[3].delay = 5;  tbl[3].err = 0; tbl[3].digit = 4'd9; tbl[3].score = 16'h7FFF;
      tbl[4].delay = -1; tbl[4].err = 1; tbl[4].digit = 4'd0; tbl[4].score = 16'h0000;

      // Reset: hold for a few edges, then check every output.
      repeat (3) @(negedge clk);
      chk_reset_values("reset");
      mon_en = 1'b1;

      // First request issued in the very cycle reset is released.
      rst = 1'b1;
      for (int v = 0; v < 5; v++)
         run_inf(tbl[v].sc, tbl[v].delay, tbl[v].err, tbl[v].digit, tbl[v].score,
                 2 + v, 1'b0, $sformatf("vec%0d", v));

      // Stale done left high from an earlier run must not shortcut the wait.
      eng_done = 1'b1;
      @(negedge clk);
      run_inf(tbl[0].sc, 4, 1'b0, 4'd2, 16'd100, 1, 1'b0, "stale_done");

      // Long hold in RESULT, then ack together with req: req is not consumed.
      run_inf(tbl[3].sc, 1, 1'b0, 4'd9, 16'h7FFF, 20, 1'b1, "hold20_ackreq");

      // Reset during SCAN at out_idx 5 aborts with everything cleared.
      for (int i = 0; i < 10; i++) scores[i] = tbl[0].sc[i];
      eng_delay = 1;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (out_idx == 4'd5) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("scan_reached_idx5", seen, 1);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_values("mid_scan_reset");
      rst = 1'b1;
      run_inf(tbl[0].sc, 1, 1'b0, 4'd2, 16'd100, 1, 1'b0, "after_reset");

      // Randomized score sets against the reference model.
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 10; i++)
            rs[i] = (r % 2 == 0) ? 16'($urandom_range(0, 65535))
                                 : 16'(int'($urandom_range(0, 6)) - 3);
         ref_argmax(rs, rd, rv);
         run_inf(rs, int'($urandom_range(1, 6)), 1'b0, rd, rv,
                 int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                 $sformatf("rand%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #200000;
      errors++;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
